// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and the default baud divider,
// so the transmitter and receiver agree on bit timing.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 104;  // 12 MHz / 115200

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte push handshake between the CPU-side bus and the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] txData;
  logic                 txValid;
  logic                 txReady;

  modport master (output txData, output txValid, input txReady);
  modport slave  (input txData, input txValid, output txReady);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; pointers carry one extra wrap bit so full and empty
// are told apart by comparing the MSBs.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, idle-high line, fed from a small byte FIFO.
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (line low) for one bit period
//   DATA  | eight data bits, shift[0] on the line
//   STOP  | stop bit (line high); chains straight into START if more queued
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic     clock,
  input  logic     reset,
  uart_tx_if.slave tx,
  output logic     uartTxPin,
  output logic     busy,
  output logic     fin
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);

  uart_state_t          state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pin_q, pin_d;

  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 bit_end;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx.txValid && tx.txReady),
    .push_data (tx.txData),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Ready depends only on the registered pointers, never on txValid.
  assign tx.txReady = !fifo_full;
  assign bit_end    = (timer_q == TIMER_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      pin_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      pin_q   <= pin_d;
    end
  end

  // The pin flop is loaded with the level of the upcoming cycle, so the
  // line changes on the same edge as the state it belongs to.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + TIMER_ONE;
    idx_d    = idx_q;
    shift_d  = shift_q;
    pin_d    = pin_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        pin_d   = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          state_d  = START;
          pin_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = DATA;
          pin_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
            pin_d   = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_ONE;
            pin_d   = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            state_d  = START;
            pin_d    = 1'b0;
          end else begin
            state_d = IDLE;
            pin_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        pin_d   = 1'b1;
      end
    endcase
  end

  assign uartTxPin = pin_q;
  assign fin       = (state_q == STOP) && bit_end;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4; a line decoder
// acts as the far-end receiver and records bytes, start times and fin pulses.
module tb_uart_tx;
  localparam int CPB = 4;

  logic clock;
  logic reset;
  logic uartTxPin;
  logic busy;
  logic fin;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int frame_err = 0;

  logic [7:0] rx_q[$];
  int         fin_times[$];
  int         start_times[$];

  uart_tx_if tx_if ();

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .tx        (tx_if),
    .uartTxPin (uartTxPin),
    .busy      (busy),
    .fin       (fin)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Far-end receiver: samples each bit at its midpoint.
  int         dcnt = 0;
  bit         dact = 0;
  logic [7:0] dbyte = 8'h00;
  always begin
    int bitn;
    @(posedge clock);
    #1;
    cyc++;
    if (!reset) begin
      dact = 0;
    end else if (!dact) begin
      if (uartTxPin === 1'b0) begin
        dact = 1;
        dcnt = 0;
        start_times.push_back(cyc);
      end
    end else begin
      dcnt++;
      if (dcnt % CPB == CPB / 2) begin
        bitn = dcnt / CPB;
        if (bitn == 0) begin
          if (uartTxPin !== 1'b0) frame_err++;
        end else if (bitn <= 8) begin
          dbyte[bitn-1] = uartTxPin;
        end else begin
          if (uartTxPin !== 1'b1) frame_err++;
          rx_q.push_back(dbyte);
        end
      end
      if (dcnt == 10 * CPB - 1) dact = 0;
    end
    if (fin === 1'b1) fin_times.push_back(cyc);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    rx_q.delete();
    fin_times.delete();
    start_times.delete();
  endtask

  // Leaves txValid high; the caller drops it when done.
  task automatic push_byte(input logic [7:0] b);
    logic rdy;
    int   t;
    tx_if.txData  = b;
    tx_if.txValid = 1'b1;
    t = 0;
    do begin
      rdy = tx_if.txReady;
      @(posedge clock);
      #1;
      t++;
    end while (rdy !== 1'b1 && t < 2000);
    n_assert++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL push_accept byte=%02h: txReady never seen high (got %b, want 1)", b, rdy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tx_if.txValid = 1'b0;
    tx_if.txData  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    n_assert++;
    if (uartTxPin !== 1'b1 || tx_if.txReady !== 1'b1 || busy !== 1'b0 || fin !== 1'b0) begin
      n_fail++;
      $display("FAIL in_reset pin/rdy/busy/fin got %b%b%b%b want 1100", uartTxPin, tx_if.txReady, busy, fin);
    end
    @(posedge clock);
    #2 reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      n_assert++;
      if (uartTxPin !== 1'b1 || tx_if.txReady !== 1'b1 || busy !== 1'b0 || fin !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset cycle %0d pin/rdy/busy/fin got %b%b%b%b want 1100",
                 i, uartTxPin, tx_if.txReady, busy, fin);
      end
    end
  endtask

  task automatic test_single();
    logic [9:0] exp_seq;
    logic       exp_fin;
    exp_seq = 10'b1101001010;  // 0xA5 framed: start, 1,0,1,0,0,1,0,1, stop
    tx_if.txData  = 8'hA5;
    tx_if.txValid = 1'b1;
    @(posedge clock);
    #1;
    tx_if.txValid = 1'b0;
    n_assert++;
    if (uartTxPin !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accept pin/busy got %b%b want 11", uartTxPin, busy);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      exp_fin = (i == 39);
      n_assert++;
      if (uartTxPin !== exp_seq[i/4]) begin
        n_fail++;
        $display("FAIL single_pin cycle %0d got %b want %b", i + 1, uartTxPin, exp_seq[i/4]);
      end
      n_assert++;
      if (fin !== exp_fin) begin
        n_fail++;
        $display("FAIL single_fin cycle %0d got %b want %b", i + 1, fin, exp_fin);
      end
    end
    @(posedge clock);
    #1;
    n_assert++;
    if (busy !== 1'b0 || fin !== 1'b0 || uartTxPin !== 1'b1) begin
      n_fail++;
      $display("FAIL single_end busy/fin/pin got %b%b%b want 001", busy, fin, uartTxPin);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    exp_b = '{8'h00, 8'hFF, 8'h3C};
    clear_logs();
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h3C);
    tx_if.txValid = 1'b0;
    for (int t = 0; t < 300 && fin_times.size() < 3; t++) @(posedge clock);
    repeat (4) @(posedge clock);
    #1;
    n_assert++;
    if (fin_times.size() != 3 || rx_q.size() != 3 || start_times.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_counts fin/rx/start got %0d/%0d/%0d want 3/3/3",
               fin_times.size(), rx_q.size(), start_times.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_assert++;
        if (rx_q[i] !== exp_b[i]) begin
          n_fail++;
          $display("FAIL b2b_byte %0d got %02h want %02h", i, rx_q[i], exp_b[i]);
        end
        n_assert++;
        if (fin_times[i] - start_times[i] != 39) begin
          n_fail++;
          $display("FAIL b2b_frame_len %0d got %0d want 39", i, fin_times[i] - start_times[i]);
        end
        if (i > 0) begin
          n_assert++;
          if (start_times[i] - start_times[i-1] != 40 || fin_times[i] - fin_times[i-1] != 40) begin
            n_fail++;
            $display("FAIL b2b_gap %0d start diff %0d fin diff %0d want 40/40", i,
                     start_times[i] - start_times[i-1], fin_times[i] - fin_times[i-1]);
          end
        end
      end
    end
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] exp_b [6];
    int t;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    clear_logs();
    for (int i = 0; i < 5; i++) push_byte(exp_b[i]);
    n_assert++;
    if (tx_if.txReady !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ready after 5 pushes rdy/busy got %b%b want 01", tx_if.txReady, busy);
    end
    tx_if.txData = exp_b[5];
    for (t = 0; t < 100 && fin !== 1'b1; t++) begin
      @(posedge clock);
      #1;
    end
    n_assert++;
    if (fin !== 1'b1 || tx_if.txReady !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_cycle fin/rdy got %b%b want 10", fin, tx_if.txReady);
    end
    @(posedge clock);
    #1;
    n_assert++;
    if (tx_if.txReady !== 1'b1) begin
      n_fail++;
      $display("FAIL full_space rdy got %b want 1", tx_if.txReady);
    end
    @(posedge clock);
    #1;
    tx_if.txValid = 1'b0;
    n_assert++;
    if (tx_if.txReady !== 1'b0) begin
      n_fail++;
      $display("FAIL full_refill rdy got %b want 0", tx_if.txReady);
    end
    for (t = 0; t < 400 && fin_times.size() < 6; t++) @(posedge clock);
    repeat (10) @(posedge clock);
    #1;
    n_assert++;
    if (rx_q.size() != 6 || fin_times.size() != 6) begin
      n_fail++;
      $display("FAIL full_count rx/fin got %0d/%0d want 6/6", rx_q.size(), fin_times.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_assert++;
        if (rx_q[i] !== exp_b[i]) begin
          n_fail++;
          $display("FAIL full_order %0d got %02h want %02h", i, rx_q[i], exp_b[i]);
        end
        if (i > 0) begin
          n_assert++;
          if (fin_times[i] - fin_times[i-1] != 40) begin
            n_fail++;
            $display("FAIL full_gap %0d got %0d want 40", i, fin_times[i] - fin_times[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int err0;
    int t;
    clear_logs();
    push_byte(8'h55);
    push_byte(8'h77);
    tx_if.txValid = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    n_assert++;
    if (uartTxPin !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_pre_reset pin got %b want 0", uartTxPin);
    end
    #2 reset = 1'b0;
    #1;
    n_assert++;
    if (uartTxPin !== 1'b1 || tx_if.txReady !== 1'b1 || busy !== 1'b0 || fin !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset pin/rdy/busy/fin got %b%b%b%b want 1100",
               uartTxPin, tx_if.txReady, busy, fin);
    end
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    n_assert++;
    if (uartTxPin !== 1'b1 || tx_if.txReady !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_release pin/rdy/busy got %b%b%b want 110", uartTxPin, tx_if.txReady, busy);
    end
    clear_logs();
    err0 = frame_err;
    push_byte(8'h81);
    tx_if.txValid = 1'b0;
    for (t = 0; t < 100 && fin_times.size() < 1; t++) @(posedge clock);
    repeat (10) @(posedge clock);
    #1;
    n_assert++;
    if (rx_q.size() != 1 || fin_times.size() != 1) begin
      n_fail++;
      $display("FAIL mid_after count rx/fin got %0d/%0d want 1/1", rx_q.size(), fin_times.size());
    end else begin
      n_assert++;
      if (rx_q[0] !== 8'h81) begin
        n_fail++;
        $display("FAIL mid_after byte got %02h want 81", rx_q[0]);
      end
    end
    n_assert++;
    if (frame_err != err0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after framing errs/busy got %0d/%b want %0d/0", frame_err, busy, err0);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] b;
    int t;
    clear_logs();
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      push_byte(b);
    end
    tx_if.txValid = 1'b0;
    for (t = 0; t < 1000 && rx_q.size() < 256; t++) @(posedge clock);
    repeat (10) @(posedge clock);
    #1;
    n_assert++;
    if (rx_q.size() != 256 || fin_times.size() != 256) begin
      n_fail++;
      $display("FAIL loop_count rx/fin got %0d/%0d want 256/256", rx_q.size(), fin_times.size());
    end
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      if (i < rx_q.size()) begin
        n_assert++;
        if (rx_q[i] !== b) begin
          n_fail++;
          $display("FAIL loop_byte %0d got %02h want %02h", i, rx_q[i], b);
        end
      end
    end
    n_assert++;
    if (frame_err != 0) begin
      n_fail++;
      $display("FAIL loop_framing errors got %0d want 0", frame_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_frame();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
